// File: rtl/glitch_reset_sync.sv
// Turns an async rising edge or sub-cycle glitch on async_in into a clean,
// clk-synchronous active-high reset pulse of SYNC_STAGES+STRETCH cycles.
module glitch_reset_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STRETCH     = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic reset_out,
  output logic busy
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LAST  = SYNC_STAGES - 1;

  if (SYNC_STAGES < 2 || STRETCH > 255) begin : g_cfg_err
    $error("glitch_reset_sync: SYNC_STAGES must be >= 2 and STRETCH <= 255");
  end

  logic                   latch_q;
  logic                   latch_clr_n;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   reset_out_q, reset_out_d;

  // Capture latch: set by any async_in rising edge, held clear while the
  // pulse is being emitted so edges during reset_out=1 are dropped.
  assign latch_clr_n = rst_n & ~reset_out_q;

  always_ff @(posedge async_in or negedge latch_clr_n) begin
    if (!latch_clr_n) begin
      latch_q <= 1'b0;
    end else begin
      latch_q <= 1'b1;
    end
  end

  // Sync chain shift, stretch reload on last-stage fall, registered pulse.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], latch_q};
    cnt_d       = cnt_q;
    reset_out_d = 1'b0;
    if (sync_q[LAST] && !sync_d[LAST]) begin
      cnt_d = CNT_W'(STRETCH);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    reset_out_d = sync_d[LAST] | (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      reset_out_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
    end
  end

  assign reset_out = reset_out_q;
  // busy must see the latch immediately, so it is an OR of flop outputs.
  assign busy      = latch_q | (|sync_q) | (cnt_q != '0);

endmodule

// File: tb/tb_glitch_reset_sync.sv
// Randomized bench for glitch_reset_sync: three parameterizations share one
// stimulus stream and are checked against a pulse-window reference model.
module tb_glitch_reset_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       async_in;
  logic [2:0] ro;
  logic [2:0] bz;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  glitch_reset_sync #(.SYNC_STAGES(2), .STRETCH(0)) u_s2 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .reset_out(ro[0]), .busy(bz[0]));
  glitch_reset_sync #(.SYNC_STAGES(3), .STRETCH(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .reset_out(ro[1]), .busy(bz[1]));
  glitch_reset_sync #(.SYNC_STAGES(4), .STRETCH(1)) u_s4 (
    .clk(clk), .rst_n(rst_n), .async_in(async_in), .reset_out(ro[2]), .busy(bz[2]));

  // Model: a pending request starts a pulse at the first clk edge E that sees
  // it; reset_out is high for cycles [E+N-1, E+2N-1+S), busy for [E, E+2N-1+S).
  int n_of[3] = '{2, 3, 4};
  int s_of[3] = '{0, 3, 1};
  bit pend[3];
  bit act[3];
  int e_cyc[3];
  int cyc;

  function automatic bit exp_ro(input int i);
    return act[i] && (cyc >= e_cyc[i] + n_of[i] - 1);
  endfunction

  function automatic bit exp_busy(input int i);
    return pend[i] || act[i];
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %b want %b at t=%0t cyc=%0d", tag, obs, exp_v, $time, cyc);
    end
  endtask

  task automatic check_all(input string where);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s reset_out[%0d]", where, i), ro[i], exp_ro(i));
      chk($sformatf("%s busy[%0d]", where, i), bz[i], exp_busy(i));
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      act[i]  = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
        act[i]  = 1'b0;
      end else begin
        if (act[i] && cyc >= e_cyc[i] + 2 * n_of[i] - 1 + s_of[i]) act[i] = 1'b0;
        if (!act[i] && pend[i]) begin
          act[i]   = 1'b1;
          e_cyc[i] = cyc;
        end
        if (act[i] && cyc == e_cyc[i] + n_of[i] - 1) pend[i] = 1'b0;
      end
    end
  endtask

  task automatic rise();
    if (async_in == 1'b0) begin
      async_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (rst_n && !exp_ro(i)) pend[i] = 1'b1;
      end
    end
  endtask

  task automatic glitch();
    if (async_in == 1'b0) begin
      rise();
      #1;
      async_in = 1'b0;
    end
  endtask

  initial begin
    int r;
    rst_n    = 1'b0;
    async_in = 1'b0;
    cyc      = 0;
    model_clear();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      check_all("edge");
      #($urandom_range(1, 2));
      if (k < 3) begin
        // power-up: edges and glitches while held in reset are discarded
        if (k == 1) glitch(); else if (async_in) async_in = 1'b0; else rise();
      end else if (k == 3) begin
        async_in = 1'b0;
        rst_n    = 1'b1;
      end else if (k == 10) begin
        rise();
      end else if (k == 35) begin
        async_in = 1'b0;
      end else if (k == 45 || k == 47) begin
        glitch();
      end else if (k >= 60) begin
        r = int'($urandom_range(0, 99));
        if (r < 25) rise();
        else if (r < 45) async_in = 1'b0;
        else if (r < 60) glitch();
        else if (r < 62 && rst_n) begin
          rst_n = 1'b0;
          model_clear();
        end else if (r < 75 && !rst_n) rst_n = 1'b1;
      end
      #1;
      check_all("mid");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
